// File: rtl/triangle_setup.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : triangle_setup
//  Description : Captures a triangle from the texel assembler, computes edge
//                deltas, cross products, signed twice-area, winding fix-up,
//                screen-clamped bounding box and cull decision, then holds
//                the set-up triangle until the rasterizer accepts it.
//
//  Port layout (flattened records):
//    vertex     [47:0]  = {z[15:0], y[15:0], x[15:0]}
//    triangle  [143:0]  = {r[47:0], q[47:0], p[47:0]}
//    colour     [23:0]  = {r[7:0], g[7:0], b[7:0]}
//
//  Revision    : 1.0  initial release
// ============================================================================
module triangle_setup #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic [143:0]  texel_vertices_in,
    input  logic [23:0]   texel_color_in,
    input  logic          texel_ready,
    output logic          texel_read,
    input  logic          raster_ready,
    output logic          tri_valid,
    output logic [143:0]  tri_vertices_out,
    output logic [23:0]   tri_color_out,
    output logic [15:0]   bbox_min_x,
    output logic [15:0]   bbox_min_y,
    output logic [15:0]   bbox_max_x,
    output logic [15:0]   bbox_max_y,
    output logic [32:0]   tri_area,
    output logic [15:0]   cull_count
);

    localparam logic [15:0] MAX_X      = 16'(SCREEN_W - 1);
    localparam logic [15:0] MAX_Y      = 16'(SCREEN_H - 1);
    localparam logic [16:0] SCREEN_W_L = 17'(SCREEN_W);
    localparam logic [16:0] SCREEN_H_L = 17'(SCREEN_H);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        DIFF    = 3'd2,
        MUL     = 3'd3,
        SETUP   = 3'd4,
        HOLD    = 3'd5
    } state_t;

    state_t state_q, state_d;

    // working registers
    logic [143:0]        verts_q, verts_d;
    logic [23:0]         color_q, color_d;
    logic signed [16:0]  dx1_q, dx1_d, dy1_q, dy1_d;
    logic signed [16:0]  dx2_q, dx2_d, dy2_q, dy2_d;
    logic signed [33:0]  prod1_q, prod1_d, prod2_q, prod2_d;

    // output registers
    logic [143:0]        vout_q, vout_d;
    logic [23:0]         cout_q, cout_d;
    logic [15:0]         bminx_q, bminx_d, bminy_q, bminy_d;
    logic [15:0]         bmaxx_q, bmaxx_d, bmaxy_q, bmaxy_d;
    logic [32:0]         area_q, area_d;
    logic [15:0]         cull_q, cull_d;

    // unpacked view of the captured vertices
    logic [47:0] p_v, q_v, r_v;
    logic [15:0] p_x, p_y, q_x, q_y, r_x, r_y;

    assign p_v = verts_q[47:0];
    assign q_v = verts_q[95:48];
    assign r_v = verts_q[143:96];
    assign p_x = p_v[15:0];
    assign p_y = p_v[31:16];
    assign q_x = q_v[15:0];
    assign q_y = q_v[31:16];
    assign r_x = r_v[15:0];
    assign r_y = r_v[31:16];

    function automatic logic [15:0] min3(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c);
        logic [15:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [15:0] max3(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c);
        logic [15:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // SETUP-stage geometry: signed area, magnitude, bbox, clamping, cull test
    logic signed [33:0] area_s;
    logic signed [33:0] area_neg;
    logic [32:0]        area_abs;
    logic               is_cw;
    logic [15:0]        min_x, min_y, max_x, max_y;
    logic [15:0]        max_x_clamped, max_y_clamped;
    logic               cull;
    logic [143:0]       ordered_verts;

    // Combinational geometry derived from the product and vertex registers
    always_comb begin
        area_s        = prod1_q - prod2_q;
        area_neg      = -area_s;
        is_cw         = area_s[33];
        area_abs      = is_cw ? area_neg[32:0] : area_s[32:0];
        min_x         = min3(p_x, q_x, r_x);
        min_y         = min3(p_y, q_y, r_y);
        max_x         = max3(p_x, q_x, r_x);
        max_y         = max3(p_y, q_y, r_y);
        max_x_clamped = (max_x > MAX_X) ? MAX_X : max_x;
        max_y_clamped = (max_y > MAX_Y) ? MAX_Y : max_y;
        cull          = (area_s == 34'sd0) ||
                        ({1'b0, min_x} >= SCREEN_W_L) ||
                        ({1'b0, min_y} >= SCREEN_H_L);
        // Clockwise input: exchange q and r (whole vertex, z included)
        ordered_verts = is_cw ? {q_v, r_v, p_v} : verts_q;
    end

    // Next-state decode and Moore handshake outputs
    always_comb begin
        state_d    = state_q;
        texel_read = 1'b0;
        tri_valid  = 1'b0;
        case (state_q)
            IDLE:    if (texel_ready) state_d = CAPTURE;
            CAPTURE: begin
                texel_read = 1'b1;
                state_d    = DIFF;
            end
            DIFF:    state_d = MUL;
            MUL:     state_d = SETUP;
            SETUP:   state_d = cull ? IDLE : HOLD;
            HOLD: begin
                tri_valid = 1'b1;
                if (raster_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values; each register only moves in its own stage
    always_comb begin
        verts_d = verts_q;
        color_d = color_q;
        dx1_d   = dx1_q;
        dy1_d   = dy1_q;
        dx2_d   = dx2_q;
        dy2_d   = dy2_q;
        prod1_d = prod1_q;
        prod2_d = prod2_q;
        vout_d  = vout_q;
        cout_d  = cout_q;
        bminx_d = bminx_q;
        bminy_d = bminy_q;
        bmaxx_d = bmaxx_q;
        bmaxy_d = bmaxy_q;
        area_d  = area_q;
        cull_d  = cull_q;
        case (state_q)
            CAPTURE: begin
                verts_d = texel_vertices_in;
                color_d = texel_color_in;
            end
            DIFF: begin
                dx1_d = $signed({1'b0, q_x} - {1'b0, p_x});
                dy1_d = $signed({1'b0, q_y} - {1'b0, p_y});
                dx2_d = $signed({1'b0, r_x} - {1'b0, p_x});
                dy2_d = $signed({1'b0, r_y} - {1'b0, p_y});
            end
            MUL: begin
                prod1_d = 34'(dx1_q) * 34'(dy2_q);
                prod2_d = 34'(dx2_q) * 34'(dy1_q);
            end
            SETUP: begin
                if (cull) begin
                    // Dropped triangles leave the presented outputs untouched
                    if (cull_q != 16'hFFFF) cull_d = cull_q + 16'd1;
                end else begin
                    vout_d  = ordered_verts;
                    cout_d  = color_q;
                    bminx_d = min_x;
                    bminy_d = min_y;
                    bmaxx_d = max_x_clamped;
                    bmaxy_d = max_y_clamped;
                    area_d  = area_abs;
                end
            end
            default: ;
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            verts_q <= '0;
            color_q <= '0;
            dx1_q   <= '0;
            dy1_q   <= '0;
            dx2_q   <= '0;
            dy2_q   <= '0;
            prod1_q <= '0;
            prod2_q <= '0;
            vout_q  <= '0;
            cout_q  <= '0;
            bminx_q <= '0;
            bminy_q <= '0;
            bmaxx_q <= '0;
            bmaxy_q <= '0;
            area_q  <= '0;
            cull_q  <= '0;
        end else begin
            state_q <= state_d;
            verts_q <= verts_d;
            color_q <= color_d;
            dx1_q   <= dx1_d;
            dy1_q   <= dy1_d;
            dx2_q   <= dx2_d;
            dy2_q   <= dy2_d;
            prod1_q <= prod1_d;
            prod2_q <= prod2_d;
            vout_q  <= vout_d;
            cout_q  <= cout_d;
            bminx_q <= bminx_d;
            bminy_q <= bminy_d;
            bmaxx_q <= bmaxx_d;
            bmaxy_q <= bmaxy_d;
            area_q  <= area_d;
            cull_q  <= cull_d;
        end
    end

    assign tri_vertices_out = vout_q;
    assign tri_color_out    = cout_q;
    assign bbox_min_x       = bminx_q;
    assign bbox_min_y       = bminy_q;
    assign bbox_max_x       = bmaxx_q;
    assign bbox_max_y       = bmaxy_q;
    assign tri_area         = area_q;
    assign cull_count       = cull_q;

endmodule
`default_nettype wire

// File: tb/tb_triangle_setup.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_triangle_setup
//  Description : Directed-vector bench for triangle_setup: table of triangles
//                with hand-computed results, plus backpressure and
//                mid-operation reset sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_triangle_setup;

    logic          clk;
    logic          n_rst;
    logic [143:0]  texel_vertices_in;
    logic [23:0]   texel_color_in;
    logic          texel_ready;
    logic          texel_read;
    logic          raster_ready;
    logic          tri_valid;
    logic [143:0]  tri_vertices_out;
    logic [23:0]   tri_color_out;
    logic [15:0]   bbox_min_x, bbox_min_y, bbox_max_x, bbox_max_y;
    logic [32:0]   tri_area;
    logic [15:0]   cull_count;

    triangle_setup #(.SCREEN_W(640), .SCREEN_H(480)) dut (
        .clk               (clk),
        .n_rst             (n_rst),
        .texel_vertices_in (texel_vertices_in),
        .texel_color_in    (texel_color_in),
        .texel_ready       (texel_ready),
        .texel_read        (texel_read),
        .raster_ready      (raster_ready),
        .tri_valid         (tri_valid),
        .tri_vertices_out  (tri_vertices_out),
        .tri_color_out     (tri_color_out),
        .bbox_min_x        (bbox_min_x),
        .bbox_min_y        (bbox_min_y),
        .bbox_max_x        (bbox_max_x),
        .bbox_max_y        (bbox_max_y),
        .tri_area          (tri_area),
        .cull_count        (cull_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [47:0]  p, q, r;
        logic [23:0]  col;
        logic         cull;
        logic [143:0] vout;
        logic [15:0]  mnx, mny, mxx, mxy;
        logic [32:0]  area;
    } vec_t;

    int n_vec  = 0;
    int n_fail = 0;

    logic [15:0]  exp_cull;
    logic [143:0] last_vout;
    logic [23:0]  last_col;
    logic [32:0]  last_area;
    logic [63:0]  last_bbox;

    vec_t tbl[8];

    function automatic logic [47:0] vtx(input int x, input int y, input int z);
        return {16'(z), 16'(y), 16'(x)};
    endfunction

    // Expected vertex order is given by hand through the swap flag
    function automatic vec_t mk(input logic [47:0] p, input logic [47:0] q,
                                input logic [47:0] r, input logic [23:0] col,
                                input logic cull, input logic swap,
                                input logic [32:0] area,
                                input int mnx, input int mny,
                                input int mxx, input int mxy);
        vec_t v;
        v.p = p; v.q = q; v.r = r; v.col = col; v.cull = cull;
        v.vout = swap ? {q, r, p} : {r, q, p};
        v.area = area;
        v.mnx = 16'(mnx); v.mny = 16'(mny); v.mxx = 16'(mxx); v.mxy = 16'(mxy);
        return v;
    endfunction

    task automatic chk(input string name, input logic [143:0] act,
                       input logic [143:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outputs_last();
        chk("vertices_kept", tri_vertices_out, last_vout);
        chk("color_kept", {120'b0, tri_color_out}, {120'b0, last_col});
        chk("area_kept", {111'b0, tri_area}, {111'b0, last_area});
        chk("bbox_kept", {80'b0, bbox_min_x, bbox_min_y, bbox_max_x, bbox_max_y},
            {80'b0, last_bbox});
    endtask

    // Push one triangle; if leave=1 the caller holds raster_ready high
    task automatic run_vec(input vec_t v, input bit leave);
        bit got;
        texel_vertices_in = {v.r, v.q, v.p};
        texel_color_in    = v.col;
        texel_ready       = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (texel_read) got = 1'b1;
        end
        chk("texel_read_seen", {143'b0, got}, 144'd1);
        texel_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("texel_read_single", {143'b0, texel_read}, 144'd0);
            if (k < 4) chk("tri_valid_early", {143'b0, tri_valid}, 144'd0);
        end
        if (v.cull) begin
            if (exp_cull != 16'hFFFF) exp_cull = exp_cull + 16'd1;
            chk("culled_no_valid", {143'b0, tri_valid}, 144'd0);
            chk("cull_count", {128'b0, cull_count}, {128'b0, exp_cull});
            chk_outputs_last();
        end else begin
            chk("tri_valid_latency", {143'b0, tri_valid}, 144'd1);
            chk("vertices", tri_vertices_out, v.vout);
            chk("color", {120'b0, tri_color_out}, {120'b0, v.col});
            chk("area", {111'b0, tri_area}, {111'b0, v.area});
            chk("bbox", {80'b0, bbox_min_x, bbox_min_y, bbox_max_x, bbox_max_y},
                {80'b0, v.mnx, v.mny, v.mxx, v.mxy});
            chk("cull_count_steady", {128'b0, cull_count}, {128'b0, exp_cull});
            last_vout = v.vout;
            last_col  = v.col;
            last_area = v.area;
            last_bbox = {v.mnx, v.mny, v.mxx, v.mxy};
            if (leave) begin
                step();
                chk("tri_valid_drop", {143'b0, tri_valid}, 144'd0);
            end
        end
    endtask

    initial begin
        bit got;

        tbl[0] = mk(vtx(10, 10, 16'h0101), vtx(20, 10, 16'h0202), vtx(10, 20, 16'h0303),
                    24'h0B1621, 1'b0, 1'b0, 33'd100, 10, 10, 20, 20);
        tbl[1] = mk(vtx(10, 10, 16'h0101), vtx(10, 20, 16'h0202), vtx(20, 10, 16'h0303),
                    24'h010203, 1'b0, 1'b1, 33'd100, 10, 10, 20, 20);
        tbl[2] = mk(vtx(0, 0, 1), vtx(5, 5, 2), vtx(10, 10, 3),
                    24'h445566, 1'b1, 1'b0, 33'd0, 0, 0, 0, 0);
        tbl[3] = mk(vtx(700, 10, 1), vtx(800, 10, 2), vtx(700, 50, 3),
                    24'h778899, 1'b1, 1'b0, 33'd0, 0, 0, 0, 0);
        tbl[4] = mk(vtx(600, 400, 16'hAAAA), vtx(700, 400, 16'hBBBB), vtx(600, 500, 16'hCCCC),
                    24'hFF0080, 1'b0, 1'b0, 33'd10000, 600, 400, 639, 479);
        tbl[5] = mk(vtx(639, 479, 16'h0011), vtx(639, 400, 16'h0022), vtx(600, 479, 16'h0033),
                    24'h123456, 1'b0, 1'b1, 33'd3081, 600, 400, 639, 479);
        tbl[6] = mk(vtx(0, 0, 16'h1000), vtx(65535, 0, 16'h2000), vtx(0, 65535, 16'h3000),
                    24'hABCDEF, 1'b0, 1'b0, 33'h0FFFE0001, 0, 0, 639, 479);
        tbl[7] = mk(vtx(0, 480, 1), vtx(10, 480, 2), vtx(0, 490, 3),
                    24'h000001, 1'b1, 1'b0, 33'd0, 0, 0, 0, 0);

        exp_cull  = '0;
        last_vout = '0;
        last_col  = '0;
        last_area = '0;
        last_bbox = '0;

        n_rst             = 1'b0;
        texel_ready       = 1'b0;
        raster_ready      = 1'b1;
        texel_vertices_in = '0;
        texel_color_in    = '0;
        repeat (3) step();
        chk("reset_texel_read", {143'b0, texel_read}, 144'd0);
        chk("reset_tri_valid", {143'b0, tri_valid}, 144'd0);
        chk("reset_cull_count", {128'b0, cull_count}, 144'd0);
        chk_outputs_last();
        n_rst = 1'b1;
        repeat (2) step();
        chk("idle_no_read", {143'b0, texel_read}, 144'd0);

        // Table of triangles with raster_ready held high
        for (int i = 0; i < 8; i++) run_vec(tbl[i], 1'b1);

        // Backpressure: hold in HOLD while upstream has a triangle waiting
        raster_ready = 1'b0;
        run_vec(tbl[0], 1'b0);
        texel_vertices_in = {tbl[1].r, tbl[1].q, tbl[1].p};
        texel_color_in    = tbl[1].col;
        texel_ready       = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_valid", {143'b0, tri_valid}, 144'd1);
            chk("bp_no_read", {143'b0, texel_read}, 144'd0);
            chk("bp_vertices", tri_vertices_out, tbl[0].vout);
            chk("bp_area", {111'b0, tri_area}, {111'b0, tbl[0].area});
        end
        raster_ready = 1'b1;
        step();
        chk("bp_release_idle_valid", {143'b0, tri_valid}, 144'd0);
        chk("bp_release_idle_read", {143'b0, texel_read}, 144'd0);
        step();
        chk("bp_next_capture", {143'b0, texel_read}, 144'd1);
        texel_ready = 1'b0;
        for (int k = 1; k <= 4; k++) step();
        chk("bp_next_valid", {143'b0, tri_valid}, 144'd1);
        chk("bp_next_vertices", tri_vertices_out, tbl[1].vout);
        last_vout = tbl[1].vout;
        last_col  = tbl[1].col;
        last_area = tbl[1].area;
        last_bbox = {tbl[1].mnx, tbl[1].mny, tbl[1].mxx, tbl[1].mxy};
        step();

        // Reset asserted while the triangle sits in MUL
        texel_vertices_in = {tbl[4].r, tbl[4].q, tbl[4].p};
        texel_color_in    = tbl[4].col;
        texel_ready       = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (texel_read) got = 1'b1;
        end
        chk("rst_seq_read", {143'b0, got}, 144'd1);
        texel_ready = 1'b0;
        step();
        step();
        n_rst = 1'b0;
        #1;
        exp_cull  = '0;
        last_vout = '0;
        last_col  = '0;
        last_area = '0;
        last_bbox = '0;
        chk("rst_mid_valid", {143'b0, tri_valid}, 144'd0);
        chk("rst_mid_read", {143'b0, texel_read}, 144'd0);
        chk("rst_mid_cull", {128'b0, cull_count}, 144'd0);
        chk_outputs_last();
        repeat (2) step();
        n_rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rst_after_quiet", {142'b0, tri_valid, texel_read}, 144'd0);
        end
        run_vec(tbl[0], 1'b1);
        run_vec(tbl[3], 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Absolute time limit so the bench always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/triangle_setup.md
TRIANGLE_SETUP -- requirements
Module: triangle_setup

Interface
REQ-001 Parameter: SCREEN_W, 640, horizontal screen extent in pixels; valid x range is 0..SCREEN_W-1.
REQ-002 Parameter: SCREEN_H, 480, vertical screen extent in pixels; valid y range is 0..SCREEN_H-1.
REQ-003 Clocking and reset SHALL be one clock with an asynchronous, active-low reset.
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 n_rst  input  1  asynchronous active-low reset.
REQ-006 texel_vertices_in  input  Triangle3D  vertices p,q,r from texel_assembler; x,y unsigned 16-bit, z passthrough.
REQ-007 texel_color_in  input  Color  triangle colour r,g,b, 8 bits each.
REQ-008 texel_ready  input  1  upstream holds a complete triangle.
REQ-009 texel_read  output  1  one-cycle pop pulse to upstream.
REQ-010 raster_ready  input  1  downstream rasterizer accepts a triangle.
REQ-011 tri_valid  output  1  set-up triangle presented.
REQ-012 tri_vertices_out  output  Triangle3D  vertices, counter-clockwise order.
REQ-013 tri_color_out  output  Color  colour passthrough.
REQ-014 bbox_min_x, bbox_min_y, bbox_max_x, bbox_max_y  output  16 each  clamped bounding box.
REQ-015 tri_area  output  33  unsigned twice-area magnitude.
REQ-016 cull_count  output  16  count of dropped triangles, saturating at 16'hFFFF.

Function
REQ-017 The FSM SHALL have states IDLE, CAPTURE, DIFF, MUL, SETUP and HOLD.
REQ-018 IDLE: texel_ready=1 -> CAPTURE; otherwise stay in IDLE.
REQ-019 CAPTURE: texel_read=1 for this one cycle only, decoded from state (Moore); the edge leaving CAPTURE latches the vertices and colour; the next state is DIFF.
REQ-020 DIFF: register 17-bit signed dx1=q.x-p.x, dy1=q.y-p.y, dx2=r.x-p.x, dy2=r.y-p.y; next state MUL.
REQ-021 MUL: register the 34-bit signed products dx1*dy2 and dx2*dy1; next state SETUP.
REQ-022 SETUP: compute A = dx1*dy2 - dx2*dy1 in 34-bit signed arithmetic; compute the bounding box as min/max over the three x and the three y values.
REQ-023 SETUP, ordering: if A<0, q and r SHALL be swapped in tri_vertices_out, including their z values; tri_area SHALL be |A| truncated to 33 bits, which is lossless.
REQ-024 SETUP, clamping: bbox_max_x SHALL be min(max_x, SCREEN_W-1) and bbox_max_y SHALL be min(max_y, SCREEN_H-1); the min values are unclamped.
REQ-025 SETUP, cull rule: a triangle is culled if A==0, min_x>=SCREEN_W, or min_y>=SCREEN_H.
REQ-026 SETUP, cull action: a culled triangle increments cull_count (saturating) and the next state is IDLE; otherwise the next state is HOLD.
REQ-027 HOLD: tri_valid=1 and all tri_*/bbox_* outputs stable; tri_valid&raster_ready at a rising edge -> IDLE, and tri_valid=0 the following cycle.
REQ-028 Latency: tri_valid SHALL rise exactly 4 cycles after the texel_read cycle; throughput is at most one triangle per 6 cycles.
REQ-029 texel_ready is ignored in every state other than IDLE; texel_read SHALL never assert while in HOLD.
REQ-030 raster_ready is ignored outside HOLD; raster_ready held high continuously is legal.
REQ-031 A culled triangle SHALL produce no tri_valid pulse; the outputs keep the values of the previous emitted triangle.

Reset
REQ-032 n_rst=0 SHALL asynchronously force the following: state IDLE, texel_read=0, tri_valid=0, cull_count=0, and all data/bbox/area registers to 0.
REQ-033 Reset asserted mid-operation, including in HOLD, SHALL discard the in-flight triangle with no tri_valid and no texel_read on release.
REQ-034 After reset release, the first texel_read SHALL occur no earlier than 1 cycle after texel_ready is sampled high in IDLE.

Verification
REQ-035 CCW triangle p=(10,10), q=(20,10), r=(10,20), colour (11,22,33), raster_ready=1 -> texel_read one cycle; tri_valid 4 cycles later; tri_area=100; bbox=(10,10)-(20,20); order unchanged; colour passthrough.
REQ-036 CW triangle p=(10,10), q=(10,20), r=(20,10) -> tri_area=100; out q=(20,10), r=(10,20); z values swapped with their vertices.
REQ-037 Collinear triangle (0,0),(5,5),(10,10) -> texel_read pulses; no tri_valid; cull_count=1; next texel_ready is accepted.
REQ-038 Off-screen triangle (700,10),(800,10),(700,50) -> culled, cull_count increments; triangle (600,400),(700,400),(600,500) -> bbox (600,400)-(639,479), tri_area=10000.
REQ-039 Backpressure: raster_ready=0 for 10 cycles in HOLD with texel_ready=1 -> tri_valid and outputs stable, no texel_read; raster_ready=1 -> IDLE then CAPTURE next triangle.
REQ-040 Reset mid-operation: n_rst pulsed low in MUL -> all outputs 0 immediately; no tri_valid after release; the next triangle is processed normally.
